pattern_sequencer: RTL and testbench
====================================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have parameter FIELDS, default 32: bytes per pattern buffer; power of two, 2..32.
REQ-002 SHALL have parameter SEQ_LEN, default 3: entries in the pattern sequence.
REQ-003 SHALL have port sclk, input, 1 bit: the only clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin playback; sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1 bit: abort playback.
REQ-007 SHALL have port pattern_sequence, input, 8*SEQ_LEN bits: entry k in bits [8k+7:8k]; bit7 = enable, bits[6:3] = repeat count, bits[2:0] = buffer index.
REQ-008 SHALL have port field_byte, input, 8 bits: buffer read data, valid one cycle after bufp/fieldp change.
REQ-009 SHALL have port bufp, output, 3 bits: buffer select to the buffer stage.
REQ-010 SHALL have port fieldp, output, 5 bits: field select to the buffer stage.
REQ-011 SHALL have port out_byte, output, 8 bits: emitted pattern byte.
REQ-012 SHALL have port out_valid, output, 1 bit: out_byte valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at normal completion.

Function
REQ-016 SHALL implement states IDLE, LOAD, FETCH, EMIT and FINISH.
REQ-017 In IDLE, start=1 SHALL clear the entry index and go to LOAD.
REQ-018 In LOAD, the entry SHALL be latched.
- If enable=0: the entry index SHALL advance, staying in LOAD, or going to FINISH after entry SEQ_LEN-1.
- Otherwise: bufp SHALL take the buffer index, fieldp 0, the repeat counter the repeat count, and the state SHALL go to FETCH.
REQ-019 FETCH SHALL last exactly one cycle (read latency); out_byte SHALL capture field_byte on exit to EMIT.
REQ-020 In EMIT, out_valid=1 and out_byte SHALL hold stable until out_valid&&out_ready.
REQ-021 On the EMIT handshake:
- fieldp<FIELDS-1: fieldp+1, state FETCH.
- Else, repeat counter>0: decrement it, fieldp=0, state FETCH.
- Else: advance the entry, state LOAD, or FINISH after the last entry.
REQ-022 Each enabled entry SHALL emit FIELDS*(repeat+1) bytes, in field order 0..FIELDS-1.
REQ-023 The first out_valid SHALL assert 3 cycles after the start edge (LOAD, FETCH, EMIT).
REQ-024 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-025 stop=1 in any state SHALL force IDLE at the next edge: out_valid=0, no done pulse, pending byte discarded.
REQ-026 stop and start both high in IDLE: stop SHALL win and remain in IDLE.
REQ-027 start while busy SHALL be ignored.
REQ-028 All sequence entries disabled: done SHALL pulse with no bytes emitted.
REQ-029 The entry index and fieldp SHALL wrap-compare against SEQ_LEN-1 and FIELDS-1; no out-of-range values.

Reset
REQ-030 rst_n=0 SHALL immediately give: state IDLE, bufp=0, fieldp=0, out_byte=0x00, out_valid=0, busy=0, done=0, all counters 0.
REQ-031 Reset mid-playback SHALL discard all progress; restart requires a new start after release.

Configuration
REQ-032 With PATSEQ_LOOP_EN defined, completion of the last entry SHALL return to LOAD with entry 0 and no done pulse, repeating until stop.
REQ-033 Without PATSEQ_LOOP_EN, a sequence SHALL play once, then pulse done (REQ-024).

Structure
REQ-034 Shared package pat_pkg SHALL hold the state enum, the widths BUF_W=3 and FIELD_W=5, and the entry bit positions.
REQ-035 One sub-module, pat_seq_ctr, SHALL implement the fieldp/repeat/entry counter cascade with wrap flags; the FSM stays in the top module.

Verification
REQ-036 Scenario: seq={0x80,0x81,0x82}, out_ready=1 -> 96 bytes; bufp 0,1,2 each with fieldp 0..31; first valid 3 cycles after start; done once.
REQ-037 Scenario: seq entry0=0x8B (repeat 1, buf 3), others 0x00 -> 64 bytes from buffer 3 (fieldp 0..31 twice), then done.
REQ-038 Scenario: out_ready toggled randomly -> out_byte stable while stalled; no byte lost or duplicated against the model.
REQ-039 Scenario: stop asserted at byte 10 -> out_valid=0 and busy=0 next cycle; no done; new start replays from byte 0.
REQ-040 Scenario: rst_n low mid-EMIT -> all outputs at reset values asynchronously; seq={0,0,0} then gives done with 0 bytes.
REQ-041 Scenario: PATSEQ_LOOP_EN build, seq={0x81,0,0} -> buffer 1 bytes repeat continuously, no done, until stop.

Source files
------------

// File: rtl/pat_pkg.sv
// Shared definitions for the pattern sequencer: FSM states, pointer widths
// and the bit layout of one pattern-sequence entry.
package pat_pkg;

  localparam int BUF_W       = 3;
  localparam int FIELD_W     = 5;
  localparam int REP_W       = 4;

  // Entry layout: [7] enable, [6:3] repeat count, [2:0] buffer index
  localparam int ENT_EN_BIT  = 7;
  localparam int ENT_REP_LSB = 3;
  localparam int ENT_BUF_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_EMIT,
    ST_FINISH
  } state_t;

  typedef struct packed {
    logic             en;
    logic [REP_W-1:0] rep;
    logic [BUF_W-1:0] buf_idx;
  } entry_t;

  function automatic entry_t decode_entry(input logic [7:0] raw);
    entry_t e;
    e.en      = raw[ENT_EN_BIT];
    e.rep     = raw[ENT_REP_LSB +: REP_W];
    e.buf_idx = raw[ENT_BUF_LSB +: BUF_W];
    return e;
  endfunction

endpackage

// File: rtl/pat_seq_ctr.sv
// Counter cascade for the pattern sequencer: field pointer, repeat counter
// and entry index, with wrap flags for the controlling FSM.
module pat_seq_ctr
  import pat_pkg::*;
#(
  parameter int FIELDS  = 32,
  parameter int SEQ_LEN = 3,
  parameter int ENTRY_W = 2
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               clr,        // return every counter to zero
  input  logic               entry_clr,  // restart at entry 0
  input  logic               load,       // arm field/repeat for a new entry
  input  logic [REP_W-1:0]   rep_in,
  input  logic               skip,       // step past a disabled entry
  input  logic               step,       // one byte accepted downstream
  output logic [FIELD_W-1:0] fieldp,
  output logic [ENTRY_W-1:0] entry_idx,
  output logic               field_last,
  output logic               rep_zero,
  output logic               entry_last
);

  logic [REP_W-1:0] rep_cnt;
  logic             entry_adv;

  assign field_last = (fieldp == FIELD_W'(FIELDS - 1));
  assign rep_zero   = (rep_cnt == '0);
  assign entry_last = (entry_idx == ENTRY_W'(SEQ_LEN - 1));
  // The entry moves on once its last field of its last repeat is consumed
  assign entry_adv  = skip || (step && field_last && rep_zero);

  // Field -> repeat -> entry cascade; every counter wraps at its limit
  // NOTE: asynchronous active-low reset lives in the sensitivity list; the
  // synchronous clear below is a separate, lower-priority function.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      fieldp    <= '0;
      rep_cnt   <= '0;
      entry_idx <= '0;
    end else if (clr) begin
      fieldp    <= '0;
      rep_cnt   <= '0;
      entry_idx <= '0;
    end else begin
      if (entry_clr) begin
        entry_idx <= '0;
      end else if (entry_adv) begin
        entry_idx <= entry_last ? '0 : entry_idx + 1'b1;
      end

      if (load) begin
        fieldp  <= '0;
        rep_cnt <= rep_in;
      end else if (step) begin
        if (!field_last) begin
          fieldp <= fieldp + 1'b1;
        end else if (!rep_zero) begin
          rep_cnt <= rep_cnt - 1'b1;
          fieldp  <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: walks a table of (enable, repeat, buffer) entries and
// streams FIELDS bytes per repeat from the selected buffer over a
// valid/ready interface.
// Build option: define PATSEQ_LOOP_EN to replay the sequence forever (no
// done pulse) until stop.
module pattern_sequencer
  import pat_pkg::*;
#(
  parameter int FIELDS  = 32,
  parameter int SEQ_LEN = 3
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [8*SEQ_LEN-1:0] pattern_sequence,
  input  logic [7:0]           field_byte,
  output logic [BUF_W-1:0]     bufp,
  output logic [FIELD_W-1:0]   fieldp,
  output logic [7:0]           out_byte,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int ENTRY_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

`ifdef PATSEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_t             state;
  entry_t             ent;
  logic [ENTRY_W-1:0] entry_idx;
  logic               field_last;
  logic               rep_zero;
  logic               entry_last;

  assign ent  = decode_entry(pattern_sequence[{entry_idx, 3'b000} +: 8]);
  assign busy = (state != ST_IDLE);

  pat_seq_ctr #(
    .FIELDS  (FIELDS),
    .SEQ_LEN (SEQ_LEN),
    .ENTRY_W (ENTRY_W)
  ) u_ctr (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .clr        (stop),
    .entry_clr  (state == ST_IDLE && start),
    .load       (state == ST_LOAD && ent.en),
    .rep_in     (ent.rep),
    .skip       (state == ST_LOAD && !ent.en),
    .step       (state == ST_EMIT && out_ready),
    .fieldp     (fieldp),
    .entry_idx  (entry_idx),
    .field_last (field_last),
    .rep_zero   (rep_zero),
    .entry_last (entry_last)
  );

  // Playback FSM with registered bufp/out_byte/out_valid/done
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bufp      <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a simultaneous start
        state     <= ST_IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) state <= ST_LOAD;
          end
          ST_LOAD: begin
            if (ent.en) begin
              bufp  <= ent.buf_idx;
              state <= ST_FETCH;
            end else if (entry_last) begin
              state <= LOOP_EN ? ST_LOAD : ST_FINISH;
              done  <= !LOOP_EN;
            end
          end
          ST_FETCH: begin
            // Buffer read data has had its one cycle of latency
            out_byte  <= field_byte;
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end
          ST_EMIT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (!(field_last && rep_zero)) begin
                state <= ST_FETCH;
              end else if (!entry_last) begin
                state <= ST_LOAD;
              end else begin
                state <= LOOP_EN ? ST_LOAD : ST_FINISH;
                done  <= !LOOP_EN;
              end
            end
          end
          ST_FINISH: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed testbench for pattern_sequencer with a combinational buffer
// model; each byte is {bufp, fieldp} ^ 0x5A so order errors are visible.
module tb_pattern_sequencer;

  logic        sclk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [23:0] pattern_sequence;
  logic [7:0]  field_byte;
  logic [2:0]  bufp;
  logic [4:0]  fieldp;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [7:0]  exp_q[$];
  int          nbytes;
  int          ndone;
  int          first_valid;

  pattern_sequencer #(
    .FIELDS  (32),
    .SEQ_LEN (3)
  ) dut (
    .sclk             (sclk),
    .rst_n            (rst_n),
    .start            (start),
    .stop             (stop),
    .pattern_sequence (pattern_sequence),
    .field_byte       (field_byte),
    .bufp             (bufp),
    .fieldp           (fieldp),
    .out_byte         (out_byte),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .done             (done)
  );

  function automatic logic [7:0] buf_byte(input logic [2:0] b, input logic [4:0] f);
    return {b, f} ^ 8'h5A;
  endfunction

  assign field_byte = buf_byte(bufp, fieldp);

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Expected byte stream for a sequence played 'copies' times
  task automatic build(input logic [23:0] seq, input int copies);
    logic [7:0] e;
    exp_q.delete();
    for (int c = 0; c < copies; c++)
      for (int k = 0; k < 3; k++) begin
        e = seq[8*k +: 8];
        if (e[7])
          for (int r = 0; r <= int'(e[6:3]); r++)
            for (int f = 0; f < 32; f++)
              exp_q.push_back(buf_byte(e[2:0], f[4:0]));
      end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bufp"},      32'(bufp),      32'd0);
    check({tag, "_fieldp"},    32'(fieldp),    32'd0);
    check({tag, "_out_byte"},  32'(out_byte),  32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
  endtask

  // Runs one playback after start has been driven high by the caller.
  // Cycle 0 is the edge that samples start.
  task automatic play(input int max_cyc, input bit rnd, input int stop_at, input bit hold_start);
    bit         stalled;
    logic [7:0] held;
    nbytes = 0; ndone = 0; first_valid = -1; stalled = 0; held = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      tick();
      if (done) ndone++;
      if (!hold_start || ndone > 0) start = 1'b0;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold",  32'(out_byte),  32'(held));
      end
      if (stop_at >= 0 && nbytes == stop_at) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_valid", 32'(out_valid), 32'd0);
        check("stop_busy",  32'(busy),      32'd0);
        check("stop_done",  32'(done),      32'd0);
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled   = out_valid && !out_ready;
      held      = out_byte;
      if (out_valid && out_ready) begin
        if (nbytes < exp_q.size()) check("byte", 32'(out_byte), 32'(exp_q[nbytes]));
        else check("byte_extra", 32'(nbytes), 32'(exp_q.size()));
        nbytes++;
      end
      if (ndone > 0) break;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    pattern_sequence = '0;
    #12;
    check_reset_values("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // stop beats start in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    check("startstop_busy", 32'(busy), 32'd0);
    start = 1'b0; stop = 1'b0;
    tick();
    check("startstop_busy2", 32'(busy), 32'd0);

`ifdef PATSEQ_LOOP_EN
    // Buffer 1 repeats forever; stop after 80 bytes (2.5 passes)
    pattern_sequence = 24'h000081;
    build(pattern_sequence, 3);
    start = 1'b1;
    play(1000, 0, 80, 0);
    check("loop_bytes", 32'(nbytes), 32'd80);
    check("loop_done",  32'(ndone),  32'd0);
`else
    // Three single-pass buffers, full throughput
    pattern_sequence = 24'h828180;
    build(pattern_sequence, 1);
    start = 1'b1;
    play(1000, 0, -1, 0);
    check("seq3_bytes",       32'(nbytes),      32'd96);
    check("seq3_done",        32'(ndone),       32'd1);
    // first valid in the third cycle: LOAD, FETCH, EMIT
    check("seq3_first_valid", 32'(first_valid), 32'd2);
    tick();
    check("seq3_done_pulse",  32'(done), 32'd0);
    check("seq3_idle",        32'(busy), 32'd0);

    // Repeat count 1 on buffer 3; start held high the whole time
    pattern_sequence = 24'h00008B;
    build(pattern_sequence, 1);
    start = 1'b1;
    play(1000, 0, -1, 1);
    check("rep_bytes", 32'(nbytes), 32'd64);
    check("rep_done",  32'(ndone),  32'd1);
    tick();
    check("rep_idle",  32'(busy), 32'd0);

    // Random backpressure: 32 bytes of buffer 5, 96 of buffer 2
    pattern_sequence = 24'h009285;
    build(pattern_sequence, 1);
    start = 1'b1;
    play(3000, 1, -1, 0);
    check("rnd_bytes", 32'(nbytes), 32'd128);
    check("rnd_done",  32'(ndone),  32'd1);

    // Abort after 10 bytes, then replay from the beginning
    pattern_sequence = 24'h828180;
    build(pattern_sequence, 1);
    tick();
    start = 1'b1;
    play(1000, 0, 10, 0);
    check("stop_bytes", 32'(nbytes), 32'd10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stop_no_done", 32'(done), 32'd0);
      check("stop_idle",    32'(busy), 32'd0);
    end
    start = 1'b1;
    play(1000, 0, -1, 0);
    check("replay_bytes", 32'(nbytes), 32'd96);
    check("replay_done",  32'(ndone),  32'd1);

    // Asynchronous reset in the middle of EMIT
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", 32'(busy), 32'd0);

    // All entries disabled: done with no bytes
    pattern_sequence = 24'h000000;
    build(pattern_sequence, 1);
    start = 1'b1;
    play(100, 0, -1, 0);
    check("empty_bytes", 32'(nbytes), 32'd0);
    check("empty_done",  32'(ndone),  32'd1);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
